result_display_driver: RTL and testbench

//   Output side of the calculator datapath: the counterpart of the operand input register.
//   - Captures a binary result on a load strobe.
//   - Converts it to BCD sequentially (double-dabble, one bit per cycle).
//   - Drives a multiplexed common-anode 7-segment display.
//   - Sits between the ALU result and the board display pins.
//

---
 rtl/calc_pkg.sv | 60 ++++++
 rtl/result_display_driver_if.sv | 34 +++
 rtl/bin2bcd_seq.sv | 149 ++++++++++++++
 rtl/result_display_driver.sv | 114 +++++++++++
 tb/tb_result_display_driver.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and helpers for the calculator display path.
//   - FSM state codes for the sequential binary-to-BCD engine
//   - Active-low 7-segment glyphs, bit order {g,f,e,d,c,b,a}
//   - bcd_digits(): decimal digits needed for the largest DATA_W-bit value
//   - seg_glyph(): nibble to glyph decode, codes above 9 map to blank
package calc_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_FIN   = 2'd2;

   localparam logic [6:0] GLYPH_0     = 7'h40;
   localparam logic [6:0] GLYPH_1     = 7'h79;
   localparam logic [6:0] GLYPH_2     = 7'h24;
   localparam logic [6:0] GLYPH_3     = 7'h30;
   localparam logic [6:0] GLYPH_4     = 7'h19;
   localparam logic [6:0] GLYPH_5     = 7'h12;
   localparam logic [6:0] GLYPH_6     = 7'h02;
   localparam logic [6:0] GLYPH_7     = 7'h78;
   localparam logic [6:0] GLYPH_8     = 7'h00;
   localparam logic [6:0] GLYPH_9     = 7'h10;
   localparam logic [6:0] GLYPH_BLANK = 7'h7F;
   localparam logic [6:0] GLYPH_MINUS = 7'h3F;

   // Number of decimal digits of 2**width-1 (elaboration-time helper).
   function automatic int bcd_digits(input int width);
      longint v;
      int     n;
      v = (longint'(1) << width) - longint'(1);
      n = 1;
      for (int i = 0; i < 19; i++) begin
         if (v >= longint'(10)) begin
            v = v / longint'(10);
            n = n + 1;
         end else begin
            v = v;
         end
      end
      return n;
   endfunction

   function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'd0:    g = GLYPH_0;
         4'd1:    g = GLYPH_1;
         4'd2:    g = GLYPH_2;
         4'd3:    g = GLYPH_3;
         4'd4:    g = GLYPH_4;
         4'd5:    g = GLYPH_5;
         4'd6:    g = GLYPH_6;
         4'd7:    g = GLYPH_7;
         4'd8:    g = GLYPH_8;
         4'd9:    g = GLYPH_9;
         default: g = GLYPH_BLANK;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/result_display_driver_if.sv
// result_display_driver_if: result handshake between the ALU side and the
// display driver.
//   master (ALU side):   drives load/result, observes busy/done/bcd[/neg]
//   slave  (driver):     observes load/result, drives busy/done/bcd[/neg]
// neg exists only when SIGNED_RESULT_EN is defined.
interface result_display_driver_if #(
   parameter int DATA_W  = 8,
   parameter int NDIGITS = 3
);
   logic                   load;
   logic [DATA_W-1:0]      result;
   logic                   busy;
   logic                   done;
   logic [4*NDIGITS-1:0]   bcd;
`ifdef SIGNED_RESULT_EN
   logic                   neg;
`endif

   modport master (
      output load, result,
      input  busy, done, bcd
`ifdef SIGNED_RESULT_EN
      , input neg
`endif
   );

   modport slave (
      input  load, result,
      output busy, done, bcd
`ifdef SIGNED_RESULT_EN
      , output neg
`endif
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one result bit per cycle.
//   clk, clear_n   clock, synchronous active-low reset
//   load, result   capture request, accepted in IDLE or FIN
//   busy           high while shifting
//   done           one-cycle pulse when bcd takes the new value
//   bcd            packed BCD, units digit in [3:0]
//   neg            sign of the converted value (SIGNED_RESULT_EN only)
// With SIGNED_RESULT_EN the DATA_W-bit unsigned magnitude is converted, so the
// most negative input converts correctly.
module bin2bcd_seq
   import calc_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int NDIGITS = 3
) (
   input  logic                 clk,
   input  logic                 clear_n,
   input  logic                 load,
   input  logic [DATA_W-1:0]    result,
   output logic                 busy,
   output logic                 done,
   output logic [4*NDIGITS-1:0] bcd
`ifdef SIGNED_RESULT_EN
   ,
   output logic                 neg
`endif
);

   // Scratch only needs enough digits for the largest magnitude.
   localparam int SCR_W = 4 * bcd_digits(DATA_W);
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [1:0]            state_r;
   logic [DATA_W-1:0]     bin_r;
   logic [SCR_W-1:0]      scr_r;
   logic [CNT_W-1:0]      cnt_r;
   logic                  busy_r;
   logic                  done_r;
   logic [4*NDIGITS-1:0]  bcd_r;
`ifdef SIGNED_RESULT_EN
   logic                  neg_r;
   logic                  neg_pend_r;
`endif
   logic                  sign_s;
   logic [DATA_W-1:0]     mag_s;
   logic [SCR_W-1:0]      adj_s;
   logic                  accept_s;

   // Sign and magnitude of the incoming result.
   always_comb begin
`ifdef SIGNED_RESULT_EN
      sign_s = result[DATA_W-1];
`else
      sign_s = 1'b0;
`endif
      if (sign_s) begin
         mag_s = {DATA_W{1'b0}} - result;
      end else begin
         mag_s = result;
      end
   end

   // Double-dabble correction: add 3 to every nibble that is 5 or more.
   always_comb begin
      adj_s = scr_r;
      for (int d = 0; d < SCR_W / 4; d++) begin
         if (scr_r[4*d +: 4] >= 4'd5) begin
            adj_s[4*d +: 4] = scr_r[4*d +: 4] + 4'd3;
         end else begin
            adj_s[4*d +: 4] = scr_r[4*d +: 4];
         end
      end
   end

   // A new load is taken when no conversion is in flight.
   always_comb begin
      if ((state_r == ST_IDLE) || (state_r == ST_FIN)) begin
         accept_s = load;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Conversion state machine and output registers.
   always_ff @(posedge clk) begin
      if (!clear_n) begin
         state_r    <= ST_IDLE;
         bin_r      <= {DATA_W{1'b0}};
         scr_r      <= {SCR_W{1'b0}};
         cnt_r      <= {CNT_W{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         bcd_r      <= {(4*NDIGITS){1'b0}};
`ifdef SIGNED_RESULT_EN
         neg_r      <= 1'b0;
         neg_pend_r <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               state_r <= ST_IDLE;
            end
            ST_SHIFT: begin
               scr_r <= {adj_s[SCR_W-2:0], bin_r[DATA_W-1]};
               bin_r <= {bin_r[DATA_W-2:0], 1'b0};
               cnt_r <= cnt_r + CNT_W'(1);
               if (cnt_r == CNT_W'(DATA_W - 1)) begin
                  state_r <= ST_FIN;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= ST_SHIFT;
               end
            end
            ST_FIN: begin
               bcd_r   <= (4*NDIGITS)'(scr_r);
               done_r  <= 1'b1;
`ifdef SIGNED_RESULT_EN
               neg_r   <= neg_pend_r;
`endif
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
         // Acceptance overrides the IDLE/FIN next-state choice above.
         if (accept_s) begin
            state_r    <= ST_SHIFT;
            bin_r      <= mag_s;
            scr_r      <= {SCR_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b1;
`ifdef SIGNED_RESULT_EN
            neg_pend_r <= sign_s;
`endif
         end
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign bcd  = bcd_r;
`ifdef SIGNED_RESULT_EN
   assign neg  = neg_r;
`endif

endmodule

// File: rtl/result_display_driver.sv
// result_display_driver: captures an ALU result, converts it to BCD and drives
// a multiplexed common-anode 7-segment display.
//   clk, clear_n   clock, synchronous active-low reset
//   bus            result_display_driver_if.slave: load, result, busy, done,
//                  bcd (and neg when SIGNED_RESULT_EN is defined)
//   seg            segments {g..a}, active-low, registered
//   an             digit enables, active-low one-hot, registered
// Optional feature macro: SIGNED_RESULT_EN (two's complement result, neg flag,
// minus glyph on the first blanked digit above the number).
module result_display_driver
   import calc_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int NDIGITS  = 3,
   parameter int SCAN_DIV = 1000
) (
   input  logic                   clk,
   input  logic                   clear_n,
   result_display_driver_if.slave bus,
   output logic [6:0]             seg,
   output logic [NDIGITS-1:0]     an
);

   localparam int IDX_W  = (NDIGITS > 1)  ? $clog2(NDIGITS)  : 1;
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [SCAN_W-1:0]  scan_r;
   logic [IDX_W-1:0]   idx_r;
   logic [IDX_W-1:0]   idx_next_s;
   logic [NDIGITS-1:0] an_r;
   logic [6:0]         seg_r;
   logic [6:0]         glyph_s;
   logic [3:0]         nib_s;
   int                 msd_s;

   bin2bcd_seq #(
      .DATA_W  (DATA_W),
      .NDIGITS (NDIGITS)
   ) u_conv (
      .clk     (clk),
      .clear_n (clear_n),
      .load    (bus.load),
      .result  (bus.result),
      .busy    (bus.busy),
      .done    (bus.done),
      .bcd     (bus.bcd)
`ifdef SIGNED_RESULT_EN
      ,
      .neg     (bus.neg)
`endif
   );

   // Digit index for the coming cycle; advances when the dwell counter wraps.
   always_comb begin
      if (scan_r == SCAN_W'(SCAN_DIV - 1)) begin
         if (idx_r == IDX_W'(NDIGITS - 1)) begin
            idx_next_s = {IDX_W{1'b0}};
         end else begin
            idx_next_s = idx_r + IDX_W'(1);
         end
      end else begin
         idx_next_s = idx_r;
      end
   end

   // Glyph for the next digit, with leading-zero blanking (units never blank).
   always_comb begin
      msd_s = 0;
      for (int d = 1; d < NDIGITS; d++) begin
         if (bus.bcd[4*d +: 4] != 4'd0) begin
            msd_s = d;
         end else begin
            msd_s = msd_s;
         end
      end
      nib_s = bus.bcd[4*idx_next_s +: 4];
      if (int'(idx_next_s) <= msd_s) begin
         glyph_s = seg_glyph(nib_s);
      end else begin
`ifdef SIGNED_RESULT_EN
         if (bus.neg && (int'(idx_next_s) == msd_s + 1)) begin
            glyph_s = GLYPH_MINUS;
         end else begin
            glyph_s = GLYPH_BLANK;
         end
`else
         glyph_s = GLYPH_BLANK;
`endif
      end
   end

   // Scanner and registered display outputs; an and seg change together.
   always_ff @(posedge clk) begin
      if (!clear_n) begin
         scan_r <= {SCAN_W{1'b0}};
         idx_r  <= {IDX_W{1'b0}};
         an_r   <= ~NDIGITS'(1);
         seg_r  <= GLYPH_0;
      end else begin
         if (scan_r == SCAN_W'(SCAN_DIV - 1)) begin
            scan_r <= {SCAN_W{1'b0}};
         end else begin
            scan_r <= scan_r + SCAN_W'(1);
         end
         idx_r <= idx_next_s;
         an_r  <= ~(NDIGITS'(1) << idx_next_s);
         seg_r <= glyph_s;
      end
   end

   assign an  = an_r;
   assign seg = seg_r;

endmodule

// File: tb/tb_result_display_driver.sv
module tb_result_display_driver;

   localparam int DATA_W   = 8;
   localparam int NDIGITS  = 3;
   localparam int SCAN_DIV = 4;

   logic       clk;
   logic       clear_n;
   logic [6:0] seg;
   logic [2:0] an;

   int chk_cnt = 0;
   int err_cnt = 0;

   // reference scanner position, tracked from the scan rules
   int m_scan = 0;
   int m_idx  = 0;

   // glyph table, active-low {g..a}
   logic [6:0] glyph_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   result_display_driver_if #(.DATA_W(DATA_W), .NDIGITS(NDIGITS)) bus ();

   result_display_driver #(
      .DATA_W   (DATA_W),
      .NDIGITS  (NDIGITS),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk     (clk),
      .clear_n (clear_n),
      .bus     (bus),
      .seg     (seg),
      .an      (an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!clear_n) begin
         m_scan <= 0;
         m_idx  <= 0;
      end else if (m_scan == SCAN_DIV - 1) begin
         m_scan <= 0;
         m_idx  <= (m_idx + 1) % NDIGITS;
      end else begin
         m_scan <= m_scan + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // magnitude and sign of a raw result under the build's interpretation
   task automatic model_val(input logic [7:0] v, output int mag, output bit ng);
`ifdef SIGNED_RESULT_EN
      if (v[7]) begin
         mag = 256 - int'(v);
         ng  = 1'b1;
      end else begin
         mag = int'(v);
         ng  = 1'b0;
      end
`else
      mag = int'(v);
      ng  = 1'b0;
`endif
   endtask

   function automatic logic [11:0] model_bcd(input int mag);
      return {4'(mag / 100 % 10), 4'(mag / 10 % 10), 4'(mag % 10)};
   endfunction

   function automatic logic [6:0] exp_seg(input int mag, input bit ng, input int idx);
      int nd;
      int p;
      nd = (mag >= 100) ? 3 : ((mag >= 10) ? 2 : 1);
      p  = (idx == 0) ? 1 : ((idx == 1) ? 10 : 100);
      if (idx < nd) return glyph_tab[(mag / p) % 10];
      if (ng && idx == nd) return 7'h3F;
      return 7'h7F;
   endfunction

   task automatic scan_check(input int mag, input bit ng, input int ncyc);
      logic [2:0] e_an;
      for (int i = 0; i < ncyc; i++) begin
         tick;
         e_an = ~(3'b001 << m_idx);
         check_eq("an", an, e_an);
         check_eq("seg", seg, exp_seg(mag, ng, m_idx));
      end
   endtask

   // waits for done, returns the number of edges it took
   task automatic wait_done(input int bound, output int n);
      n = 0;
      do begin
         tick;
         n++;
      end while (!bus.done && n < bound);
      if (!bus.done) check_eq("done_timeout", bus.done, 1'b1);
   endtask

   // full conversion with cycle-exact busy/done checks
   task automatic convert(input logic [7:0] v);
      int mag;
      bit ng;
      model_val(v, mag, ng);
      bus.load   = 1'b1;
      bus.result = v;
      tick;
      bus.load = 1'b0;
      for (int k = 0; k < DATA_W; k++) begin
         check_eq("busy", bus.busy, 1'b1);
         check_eq("done_early", bus.done, 1'b0);
         tick;
      end
      check_eq("busy_fin", bus.busy, 1'b0);
      check_eq("done_fin", bus.done, 1'b0);
      tick;
      check_eq("done", bus.done, 1'b1);
      check_eq("bcd", bus.bcd, model_bcd(mag));
`ifdef SIGNED_RESULT_EN
      check_eq("neg", bus.neg, ng);
`endif
      tick;
      check_eq("done_pulse", bus.done, 1'b0);
   endtask

   initial begin
      int n;
      int mag;
      bit ng;
      logic [7:0] rv;

      clear_n    = 1'b0;
      bus.load   = 1'b0;
      bus.result = 8'd0;
      tick;
      tick;
      check_eq("rst_busy", bus.busy, 1'b0);
      check_eq("rst_done", bus.done, 1'b0);
      check_eq("rst_bcd", bus.bcd, 12'h000);
      check_eq("rst_an", an, 3'b110);
      check_eq("rst_seg", seg, 7'h40);
      clear_n = 1'b1;

      // basic conversions with display scan
      foreach (glyph_tab[i]) begin end
      convert(8'd255);
      model_val(8'd255, mag, ng);
      scan_check(mag, ng, 12);
      convert(8'd7);
      scan_check(7, 1'b0, 24);
      convert(8'd0);
      scan_check(0, 1'b0, 12);

      // load while busy is ignored
      bus.load   = 1'b1;
      bus.result = 8'd7;
      tick;
      bus.result = 8'd99;
      tick;
      tick;
      bus.load = 1'b0;
      wait_done(20, n);
      check_eq("busy_ign_bcd", bus.bcd, 12'h007);
      // load during the done cycle
      bus.load   = 1'b1;
      bus.result = 8'd99;
      tick;
      bus.load = 1'b0;
      wait_done(20, n);
      check_eq("done_cycle_lat", n, 9);
      check_eq("done_cycle_bcd", bus.bcd, 12'h099);

      // load accepted in the FIN cycle (busy low, done not yet)
      bus.load   = 1'b1;
      bus.result = 8'd42;
      tick;
      bus.load = 1'b0;
      n = 0;
      while (bus.busy && n < 20) begin
         tick;
         n++;
      end
      check_eq("fin_busy_low", bus.busy, 1'b0);
      bus.load   = 1'b1;
      bus.result = 8'd123;
      tick;
      bus.load = 1'b0;
      check_eq("fin_done", bus.done, 1'b1);
      check_eq("fin_bcd", bus.bcd, 12'h042);
      wait_done(20, n);
      check_eq("fin_lat", n, 9);
      check_eq("fin_bcd2", bus.bcd, 12'h123);

      // randomized conversions
      for (int r = 0; r < 10; r++) begin
         rv = 8'($urandom_range(0, 255));
         convert(rv);
         model_val(rv, mag, ng);
         scan_check(mag, ng, 12);
      end

`ifdef SIGNED_RESULT_EN
      convert(8'h80);
      check_eq("s80_bcd", bus.bcd, 12'h128);
      scan_check(128, 1'b1, 12);
      convert(8'hFB);
      check_eq("sFB_bcd", bus.bcd, 12'h005);
      check_eq("sFB_neg", bus.neg, 1'b1);
      scan_check(5, 1'b1, 12);
`endif

      // reset in the middle of a conversion
      bus.load   = 1'b1;
      bus.result = 8'd200;
      tick;
      bus.load = 1'b0;
      tick;
      tick;
      tick;
      clear_n = 1'b0;
      tick;
      clear_n = 1'b1;
      check_eq("mid_busy", bus.busy, 1'b0);
      check_eq("mid_bcd", bus.bcd, 12'h000);
      check_eq("mid_an", an, 3'b110);
      for (int i = 0; i < 12; i++) begin
         tick;
         check_eq("mid_no_done", bus.done, 1'b0);
         check_eq("mid_busy_low", bus.busy, 1'b0);
      end
      scan_check(0, 1'b0, 12);

      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
